// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared word width, wait-state limit and responder state encoding
package mips_pkg;

    localparam int WORD_W          = 32;
    localparam int MAX_WAIT_STATES = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word RAM, synchronous write, registered read, no reset
module dmem_array #(
    parameter int  DEPTH = 256,
    parameter int  WIDTH = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write and read share one port; rdata only moves on a read so it holds between accesses
    always_ff @(posedge clock) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store responder with fixed wait states; DMEM_ALIGN_CHECK_EN rejects misaligned addresses
module dmem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [WORD_W-1:0] address,
    input  logic [WORD_W-1:0] writedata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] readdata,
    output logic              resp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MAX_WAIT_STATES + 1);
    localparam bit NO_WAIT = (WAIT_STATES == 0);
    // Counter preload; out-of-range settings are clamped to the largest supported wait
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > MAX_WAIT_STATES) ? CNT_W'(MAX_WAIT_STATES - 1) :
        (WAIT_STATES > 0)               ? CNT_W'(WAIT_STATES - 1)     : '0;

    dmem_state_t state, state_nxt;

    logic [CNT_W-1:0]  wait_cnt;
    logic              rd_q;
    logic              wr_q;
    logic              mis_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic              err_q;
    logic              rd_sel_q;

    logic              accept;
    logic              access;
    logic [IDX_W-1:0]  in_idx;
    logic              in_mis;
    logic              cur_rd;
    logic              cur_wr;
    logic              cur_mis;
    logic [IDX_W-1:0]  cur_idx;
    logic [WORD_W-1:0] cur_wdata;
    logic              cur_err;
    logic              mem_we;
    logic              mem_re;
    logic [WORD_W-1:0] arr_rdata;

    assign in_idx = address[IDX_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign in_mis = |address[1:0];
`else
    assign in_mis = 1'b0;
    logic unused_addr_lo;
    assign unused_addr_lo = ^address[1:0];
`endif

    generate
        if (IDX_W + 2 < WORD_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^address[WORD_W-1:IDX_W+2];
        end
    endgenerate

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = (state == IDLE) && req_valid;
    assign access     = (accept && NO_WAIT) || ((state == WAIT) && (wait_cnt == '0));

    // With no wait states the access happens on the accept edge, so use the live request
    assign cur_rd    = (state == IDLE) ? memread   : rd_q;
    assign cur_wr    = (state == IDLE) ? memwrite  : wr_q;
    assign cur_mis   = (state == IDLE) ? in_mis    : mis_q;
    assign cur_idx   = (state == IDLE) ? in_idx    : idx_q;
    assign cur_wdata = (state == IDLE) ? writedata : wdata_q;

    assign cur_err = (cur_rd == cur_wr) || cur_mis;
    assign mem_we  = access && cur_wr && !cur_err;
    assign mem_re  = access && cur_rd && !cur_err;

    // readdata is forced to zero unless the response is a successful load
    assign readdata = rd_sel_q ? arr_rdata : '0;
    assign resp_err = err_q;

    dmem_array #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_array (
        .clock (clock),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (cur_idx),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

    // State register
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid)        state_nxt = NO_WAIT ? RESP : WAIT;
            WAIT: if (wait_cnt == '0)   state_nxt = RESP;
            RESP: if (resp_ready)       state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Request capture and wait-state countdown
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            wait_cnt <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            mis_q    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
        end else if (accept) begin
            wait_cnt <= WAIT_LOAD;
            rd_q     <= memread;
            wr_q     <= memwrite;
            mis_q    <= in_mis;
            idx_q    <= in_idx;
            wdata_q  <= writedata;
        end else if ((state == WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // Response status: set on the access edge, cleared by the response handshake
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            err_q    <= 1'b0;
            rd_sel_q <= 1'b0;
        end else if (access) begin
            err_q    <= cur_err;
            rd_sel_q <= mem_re;
        end else if ((state == RESP) && resp_ready) begin
            err_q    <= 1'b0;
            rd_sel_q <= 1'b0;
        end
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder: the memory end of the processor's load/store port. It accepts one request at a time from the CPU datapath (memread / memwrite, address, write data) and completes it after a fixed number of wait states. It returns `readdata` and an error flag through a valid/ready response handshake. It sits between the datapath's ALU result / ReadData2 nets and the `mux_data` write-back input, replacing a zero-latency combinational memory.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, at least 2.
- `WAIT_STATES`, 2: extra cycles between request acceptance and the memory access; 0 to 15.
- `clock`  in  1  single clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `memread`  in  1  load request.
- `memwrite`  in  1  store request.
- `address`  in  32  byte address; word index is `address[log2(DEPTH)+1:2]`.
- `writedata`  in  32  store data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  datapath takes the response.
- `readdata`  out  32  load data; 0 for stores and errors.
- `resp_err`  out  1  request rejected, no memory side effect.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` (accept edge), latch memread, memwrite, address and writedata.
  - If `WAIT_STATES`=0, go to ACCESS handling immediately (see below). Otherwise load the wait counter with `WAIT_STATES`-1 and go to WAIT.
- WAIT: the counter decrements each cycle. When it reaches 0, go to ACCESS handling.
- ACCESS handling happens on one edge and is not a separate state. The memory is accessed on that edge and the FSM enters RESP. The edge is the accept edge when `WAIT_STATES`=0, otherwise the last WAIT edge. On that edge:
  - Store: `mem[idx] <= writedata`.
  - Load: `readdata <=` `mem[idx]` (the stored value before any write on that edge).
  - Both memread and memwrite set: `resp_err`=1, no write.
  - Neither set: `resp_err`=1, no write.
- RESP:
  - `resp_valid`=1, and `readdata` / `resp_err` are held stable.
  - On `resp_ready`, clear `resp_valid`, zero `readdata` and `resp_err`, and return to IDLE.
- Address bits above the word index are ignored; the address wraps modulo `DEPTH` words.
- Requests presented while `req_ready`=0 are not accepted. The datapath must hold them.
- Memory array contents are not reset.

## Timing
- Reset values: `req_ready`=1, `resp_valid`=0, `readdata`=0, `resp_err`=0, state IDLE, wait counter 0.
- Reset asserted mid-request returns to IDLE at once.
  - If it is asserted before the access edge, the pending store is discarded.
  - A store already performed stays in memory.
- Latency: `resp_valid` rises `WAIT_STATES`+1 cycles after the accept edge.
- Minimum spacing between accept edges is `WAIT_STATES`+2 cycles. `req_ready` returns the cycle after the response handshake edge.
- `req_ready` is a registered state decode with no combinational path from `req_valid` or `resp_ready`.
- `resp_ready` held low stalls indefinitely in RESP, with outputs unchanged.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined: if `address[1:0]` is not 0 at acceptance, the request completes with the normal latency but with `resp_err`=1, `readdata`=0 and no write.
- `DMEM_ALIGN_CHECK_EN` undefined: `address[1:0]` is ignored and the access goes to the containing word.

## Structure
- Shared package `mips_pkg`:
  - `WORD_W`=32.
  - The `dmem_state_t` enum (IDLE, WAIT, RESP).
  - The `MAX_WAIT_STATES`=15 constant.
- Sub-module `dmem_array`: single-port RAM with synchronous write, registered read, `DEPTH` words, no reset.
- The FSM, wait counter and error logic live in `dmem_responder`.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10 with `WAIT_STATES`=2 -> `resp_valid` 3 cycles after acceptance, `resp_err`=0, `readdata`=0. A following load from 0x10 returns 0xDEADBEEF.
- `WAIT_STATES`=0: load from 0x10 accepted at edge t -> `resp_valid` at t+1. Back-to-back loads are accepted every 2 cycles.
- memread and memwrite both 1 at 0x20 with writedata 0x1234 -> `resp_err`=1. A later load from 0x20 returns its prior contents.
- `resp_ready` held low for 5 cycles in RESP -> `resp_valid`, `readdata` and `req_ready`=0 stable. A new `req_valid` is not accepted until after the handshake.
- `Reset` pulsed during WAIT of a store of 0xCAFEF00D to 0x40 -> outputs return to reset values immediately. A later load from 0x40 returns the old value.
- With `DMEM_ALIGN_CHECK_EN` defined: store to 0x42 -> `resp_err`=1 and word 0x40 unchanged. Without the macro: the same store writes word 0x40.
